// File: rtl/tcp_rx_ctrl.sv
// rtl/tcp_rx_ctrl.sv - receive-side TCP segment classifier and sequence/ack/window tracker
module tcp_rx_ctrl #(
  parameter int DROP_CNT_W = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [31:0]           i_seq_number,
  input  logic [31:0]           i_ack_number,
  input  logic [7:0]            i_flags,
  input  logic [15:0]           i_window_size,
  input  logic [15:0]           i_payload_len,
  input  logic                  i_hdr_valid,
  output logic                  o_hdr_ready,
  input  logic                  i_conn_reset,
  output logic [2:0]            o_rx_ctrl,
  output logic                  o_rx_ctrl_valid,
  input  logic                  i_rx_ctrl_ack,
  output logic [31:0]           o_rcv_nxt,
  output logic [31:0]           o_remote_ack,
  output logic [15:0]           o_remote_window,
  output logic [DROP_CNT_W-1:0] o_drop_count
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_CLASSIFY = 2'd1,
    S_REPORT   = 2'd2
  } state_t;

  // Flag bit positions, shared with the TX header-generation side.
  localparam int FLAG_FIN = 0;
  localparam int FLAG_SYN = 1;
  localparam int FLAG_RST = 2;
  localparam int FLAG_ACK = 4;

  localparam logic [2:0] EV_NONE    = 3'd0;
  localparam logic [2:0] EV_SYN     = 3'd1;
  localparam logic [2:0] EV_SYN_ACK = 3'd2;
  localparam logic [2:0] EV_ACK     = 3'd3;
  localparam logic [2:0] EV_FIN     = 3'd4;
  localparam logic [2:0] EV_RST     = 3'd5;

  state_t                state_q, state_d;
  logic [31:0]           seq_q, seq_d;
  logic [31:0]           ack_q, ack_d;
  logic [7:0]            flags_q, flags_d;
  logic [15:0]           win_q, win_d;
  logic [15:0]           len_q, len_d;
  logic [2:0]            rx_ctrl_q, rx_ctrl_d;
  logic                  rx_ctrl_valid_q, rx_ctrl_valid_d;
  logic [31:0]           rcv_nxt_q, rcv_nxt_d;
  logic [31:0]           remote_ack_q, remote_ack_d;
  logic [15:0]           remote_window_q, remote_window_d;
  logic [DROP_CNT_W-1:0] drop_count_q, drop_count_d;

  logic                  accept;
  logic [2:0]            code;
  logic [31:0]           new_rcv_nxt;
  logic                  in_seq;
  logic [31:0]           len_ext;

  assign len_ext = {16'd0, len_q};
  assign in_seq  = (seq_q == rcv_nxt_q);

  // Classify the latched header: first matching flag wins, FIN/ACK need in-sequence seq.
  always_comb begin
    accept      = 1'b0;
    code        = EV_NONE;
    new_rcv_nxt = rcv_nxt_q;
    if (flags_q[FLAG_RST]) begin
      accept = 1'b1;
      code   = EV_RST;
    end else if (flags_q[FLAG_SYN] && flags_q[FLAG_ACK]) begin
      accept      = 1'b1;
      code        = EV_SYN_ACK;
      new_rcv_nxt = seq_q + 32'd1;
    end else if (flags_q[FLAG_SYN]) begin
      accept      = 1'b1;
      code        = EV_SYN;
      new_rcv_nxt = seq_q + 32'd1;
    end else if (flags_q[FLAG_FIN]) begin
      accept      = in_seq;
      code        = EV_FIN;
      new_rcv_nxt = rcv_nxt_q + len_ext + 32'd1;
    end else if (flags_q[FLAG_ACK]) begin
      accept      = in_seq;
      code        = EV_ACK;
      new_rcv_nxt = rcv_nxt_q + len_ext;
    end
  end

  // Next-state and tracking-state update; connection reset overrides all but the drop counter.
  always_comb begin
    state_d         = state_q;
    seq_d           = seq_q;
    ack_d           = ack_q;
    flags_d         = flags_q;
    win_d           = win_q;
    len_d           = len_q;
    rx_ctrl_d       = rx_ctrl_q;
    rx_ctrl_valid_d = rx_ctrl_valid_q;
    rcv_nxt_d       = rcv_nxt_q;
    remote_ack_d    = remote_ack_q;
    remote_window_d = remote_window_q;
    drop_count_d    = drop_count_q;

    case (state_q)
      S_IDLE: begin
        if (i_hdr_valid) begin
          seq_d   = i_seq_number;
          ack_d   = i_ack_number;
          flags_d = i_flags;
          win_d   = i_window_size;
          len_d   = i_payload_len;
          state_d = S_CLASSIFY;
        end
      end
      S_CLASSIFY: begin
        if (accept) begin
          rx_ctrl_d       = code;
          rx_ctrl_valid_d = 1'b1;
          rcv_nxt_d       = new_rcv_nxt;
          remote_window_d = win_q;
          if (flags_q[FLAG_ACK]) begin
            remote_ack_d = ack_q;
          end
          state_d = S_REPORT;
        end else begin
          if (drop_count_q != {DROP_CNT_W{1'b1}}) begin
            drop_count_d = drop_count_q + 1'b1;
          end
          state_d = S_IDLE;
        end
      end
      S_REPORT: begin
        if (i_rx_ctrl_ack) begin
          rx_ctrl_d       = EV_NONE;
          rx_ctrl_valid_d = 1'b0;
          state_d         = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (i_conn_reset) begin
      state_d         = S_IDLE;
      rx_ctrl_d       = EV_NONE;
      rx_ctrl_valid_d = 1'b0;
      rcv_nxt_d       = 32'd0;
      remote_ack_d    = 32'd0;
      remote_window_d = 16'd0;
      drop_count_d    = drop_count_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q         <= S_IDLE;
      seq_q           <= 32'd0;
      ack_q           <= 32'd0;
      flags_q         <= 8'd0;
      win_q           <= 16'd0;
      len_q           <= 16'd0;
      rx_ctrl_q       <= EV_NONE;
      rx_ctrl_valid_q <= 1'b0;
      rcv_nxt_q       <= 32'd0;
      remote_ack_q    <= 32'd0;
      remote_window_q <= 16'd0;
      drop_count_q    <= '0;
    end else begin
      state_q         <= state_d;
      seq_q           <= seq_d;
      ack_q           <= ack_d;
      flags_q         <= flags_d;
      win_q           <= win_d;
      len_q           <= len_d;
      rx_ctrl_q       <= rx_ctrl_d;
      rx_ctrl_valid_q <= rx_ctrl_valid_d;
      rcv_nxt_q       <= rcv_nxt_d;
      remote_ack_q    <= remote_ack_d;
      remote_window_q <= remote_window_d;
      drop_count_q    <= drop_count_d;
    end
  end

  assign o_hdr_ready     = (state_q == S_IDLE);
  assign o_rx_ctrl       = rx_ctrl_q;
  assign o_rx_ctrl_valid = rx_ctrl_valid_q;
  assign o_rcv_nxt       = rcv_nxt_q;
  assign o_remote_ack    = remote_ack_q;
  assign o_remote_window = remote_window_q;
  assign o_drop_count    = drop_count_q;

endmodule

// File: tb/tb_tcp_rx_ctrl.sv
// tb/tb_tcp_rx_ctrl.sv - directed self-checking bench for tcp_rx_ctrl
module tb_tcp_rx_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] seq_number;
  logic [31:0] ack_number;
  logic [7:0]  flags;
  logic [15:0] window_size;
  logic [15:0] payload_len;
  logic        hdr_valid;
  logic        conn_reset;
  logic        rx_ctrl_ack;

  logic        hdr_ready;
  logic [2:0]  rx_ctrl;
  logic        rx_ctrl_valid;
  logic [31:0] rcv_nxt;
  logic [31:0] remote_ack;
  logic [15:0] remote_window;
  logic [15:0] drop_count;

  logic        hdr_ready2;
  logic [2:0]  rx_ctrl2;
  logic        rx_ctrl_valid2;
  logic [31:0] rcv_nxt2;
  logic [31:0] remote_ack2;
  logic [15:0] remote_window2;
  logic [1:0]  drop_count2;

  int checks;
  int failures;

  tcp_rx_ctrl #(.DROP_CNT_W(16)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_seq_number(seq_number), .i_ack_number(ack_number), .i_flags(flags),
    .i_window_size(window_size), .i_payload_len(payload_len),
    .i_hdr_valid(hdr_valid), .o_hdr_ready(hdr_ready),
    .i_conn_reset(conn_reset),
    .o_rx_ctrl(rx_ctrl), .o_rx_ctrl_valid(rx_ctrl_valid), .i_rx_ctrl_ack(rx_ctrl_ack),
    .o_rcv_nxt(rcv_nxt), .o_remote_ack(remote_ack), .o_remote_window(remote_window),
    .o_drop_count(drop_count)
  );

  // Narrow-counter instance fed the same stimulus, to reach saturation quickly.
  tcp_rx_ctrl #(.DROP_CNT_W(2)) dut_sat (
    .i_clk(clk), .i_rst(rst),
    .i_seq_number(seq_number), .i_ack_number(ack_number), .i_flags(flags),
    .i_window_size(window_size), .i_payload_len(payload_len),
    .i_hdr_valid(hdr_valid), .o_hdr_ready(hdr_ready2),
    .i_conn_reset(conn_reset),
    .o_rx_ctrl(rx_ctrl2), .o_rx_ctrl_valid(rx_ctrl_valid2), .i_rx_ctrl_ack(rx_ctrl_ack),
    .o_rcv_nxt(rcv_nxt2), .o_remote_ack(remote_ack2), .o_remote_window(remote_window2),
    .o_drop_count(drop_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a header for one cycle (accepted in IDLE), then advance to T+2.
  task automatic send(input logic [7:0] f, input logic [31:0] s, input logic [31:0] a,
                      input logic [15:0] w, input logic [15:0] l);
    flags = f; seq_number = s; ack_number = a; window_size = w; payload_len = l;
    hdr_valid = 1'b1;
    step();
    hdr_valid = 1'b0;
    step();
  endtask

  task automatic do_ack();
    rx_ctrl_ack = 1'b1;
    step();
    rx_ctrl_ack = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; hdr_valid = 1'b0; conn_reset = 1'b0; rx_ctrl_ack = 1'b0;
    seq_number = '0; ack_number = '0; flags = '0; window_size = '0; payload_len = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_ready", {31'd0, hdr_ready}, 32'd1);
    chk("rst_valid", {31'd0, rx_ctrl_valid}, 32'd0);
    chk("rst_ctrl", {29'd0, rx_ctrl}, 32'd0);
    chk("rst_rcv_nxt", rcv_nxt, 32'd0);
    chk("rst_drop", {16'd0, drop_count}, 32'd0);

    // SYN-ACK; event must not be visible at T+1.
    flags = 8'h12; seq_number = 32'h1000_0000; ack_number = 32'h0000_0101;
    window_size = 16'h4000; payload_len = 16'd0; hdr_valid = 1'b1;
    step();
    hdr_valid = 1'b0;
    chk("synack_t1_valid", {31'd0, rx_ctrl_valid}, 32'd0);
    chk("synack_t1_ready", {31'd0, hdr_ready}, 32'd0);
    step();
    chk("synack_ctrl", {29'd0, rx_ctrl}, 32'd2);
    chk("synack_valid", {31'd0, rx_ctrl_valid}, 32'd1);
    chk("synack_rcv_nxt", rcv_nxt, 32'h1000_0001);
    chk("synack_remote_ack", remote_ack, 32'h0000_0101);
    chk("synack_window", {16'd0, remote_window}, 32'h4000);
    do_ack();
    chk("ack_clear_valid", {31'd0, rx_ctrl_valid}, 32'd0);
    chk("ack_clear_ctrl", {29'd0, rx_ctrl}, 32'd0);
    chk("ack_clear_ready", {31'd0, hdr_ready}, 32'd1);

    // In-sequence ACK with 100 bytes.
    send(8'h10, 32'h1000_0001, 32'h0000_0202, 16'h3000, 16'd100);
    chk("ack_ctrl", {29'd0, rx_ctrl}, 32'd3);
    chk("ack_rcv_nxt", rcv_nxt, 32'h1000_0065);
    chk("ack_remote_ack", remote_ack, 32'h0000_0202);
    chk("ack_window", {16'd0, remote_window}, 32'h3000);
    do_ack();

    // Out-of-sequence ACK is dropped.
    send(8'h10, 32'h1000_0000, 32'h0000_0303, 16'h2000, 16'd100);
    chk("oos_valid", {31'd0, rx_ctrl_valid}, 32'd0);
    chk("oos_drop", {16'd0, drop_count}, 32'd1);
    chk("oos_rcv_nxt", rcv_nxt, 32'h1000_0065);
    chk("oos_remote_ack", remote_ack, 32'h0000_0202);
    chk("oos_ready", {31'd0, hdr_ready}, 32'd1);

    // Sequence wrap-around.
    send(8'h02, 32'hFFFF_FFFE, 32'h0, 16'h1000, 16'd0);
    chk("syn_ctrl", {29'd0, rx_ctrl}, 32'd1);
    chk("syn_rcv_nxt", rcv_nxt, 32'hFFFF_FFFF);
    do_ack();
    send(8'h10, 32'hFFFF_FFFF, 32'h0000_0404, 16'h1000, 16'd3);
    chk("wrap_ctrl", {29'd0, rx_ctrl}, 32'd3);
    chk("wrap_rcv_nxt", rcv_nxt, 32'h0000_0002);
    do_ack();

    // FIN beats ACK; hold the event without ack for 5 cycles.
    send(8'h11, 32'h0000_0002, 32'h0000_0555, 16'h0100, 16'd0);
    chk("fin_ctrl", {29'd0, rx_ctrl}, 32'd4);
    chk("fin_rcv_nxt", rcv_nxt, 32'h0000_0003);
    chk("fin_remote_ack", remote_ack, 32'h0000_0555);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_valid", {31'd0, rx_ctrl_valid}, 32'd1);
      chk("hold_ctrl", {29'd0, rx_ctrl}, 32'd4);
      chk("hold_ready", {31'd0, hdr_ready}, 32'd0);
    end
    do_ack();

    // RST accepted with mismatched seq; rcv_nxt untouched.
    send(8'h04, 32'h1234_5678, 32'h0, 16'h0200, 16'd0);
    chk("rst_ev_ctrl", {29'd0, rx_ctrl}, 32'd5);
    chk("rst_ev_rcv_nxt", rcv_nxt, 32'h0000_0003);
    chk("rst_ev_remote_ack", remote_ack, 32'h0000_0555);
    chk("rst_ev_window", {16'd0, remote_window}, 32'h0200);
    do_ack();

    // PSH only: no usable flags.
    send(8'h08, 32'h0000_0003, 32'h0, 16'h0300, 16'd0);
    chk("psh_valid", {31'd0, rx_ctrl_valid}, 32'd0);
    chk("psh_drop", {16'd0, drop_count}, 32'd2);

    // Connection reset while an event is pending.
    send(8'h02, 32'h0000_0050, 32'h0, 16'h0400, 16'd0);
    chk("pend_valid", {31'd0, rx_ctrl_valid}, 32'd1);
    chk("pend_rcv_nxt", rcv_nxt, 32'h0000_0051);
    conn_reset = 1'b1;
    step();
    conn_reset = 1'b0;
    chk("creset_valid", {31'd0, rx_ctrl_valid}, 32'd0);
    chk("creset_ctrl", {29'd0, rx_ctrl}, 32'd0);
    chk("creset_rcv_nxt", rcv_nxt, 32'd0);
    chk("creset_remote_ack", remote_ack, 32'd0);
    chk("creset_window", {16'd0, remote_window}, 32'd0);
    chk("creset_ready", {31'd0, hdr_ready}, 32'd1);
    chk("creset_drop", {16'd0, drop_count}, 32'd2);

    // Drive the 2-bit counter into saturation.
    chk("sat_pre", {30'd0, drop_count2}, 32'd2);
    for (int i = 0; i < 3; i++) begin
      send(8'h08, 32'h0, 32'h0, 16'h0, 16'd0);
    end
    chk("sat_wide", {16'd0, drop_count}, 32'd5);
    chk("sat_narrow", {30'd0, drop_count2}, 32'd3);

    // Reset mid-operation.
    send(8'h02, 32'h0000_0007, 32'h0, 16'h0500, 16'd0);
    chk("midrst_pre_valid", {31'd0, rx_ctrl_valid}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_valid", {31'd0, rx_ctrl_valid}, 32'd0);
    chk("midrst_rcv_nxt", rcv_nxt, 32'd0);
    chk("midrst_drop", {16'd0, drop_count}, 32'd0);
    chk("midrst_ready", {31'd0, hdr_ready}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tcp_rx_ctrl.md
Name: tcp_rx_ctrl

Overview:
Receive-side TCP control block. It accepts parsed TCP header fields from the RX header parser and classifies each segment into one control event (SYN, SYN-ACK, ACK, FIN, RST) for the connection state machine. It also tracks the expected remote sequence number (rcv_nxt), the peer's last acknowledgement and the peer's window. It is the receive counterpart of the TX header-generation control and shares its flag bit encoding.

Parameters:
DROP_CNT_W, 16, width of the saturating dropped-segment counter

Ports:
i_clk  input  1  clock
i_rst  input  1  synchronous active-high reset
i_seq_number  input  32  segment sequence number
i_ack_number  input  32  segment acknowledgement number
i_flags  input  8  TCP flags: FIN=bit0, SYN=bit1, RST=bit2, PSH=bit3, ACK=bit4, URG=bit5, ECE=bit6, CWR=bit7
i_window_size  input  16  advertised window
i_payload_len  input  16  payload bytes in segment
i_hdr_valid  input  1  header fields valid
o_hdr_ready  output  1  block can accept a header
i_conn_reset  input  1  clear per-connection tracking state
o_rx_ctrl  output  3  event code: 0 NONE, 1 SYN, 2 SYN_ACK, 3 ACK, 4 FIN, 5 RST
o_rx_ctrl_valid  output  1  event valid
i_rx_ctrl_ack  input  1  consumer accepts event
o_rcv_nxt  output  32  next expected remote sequence number
o_remote_ack  output  32  last accepted peer ack number
o_remote_window  output  16  last accepted peer window
o_drop_count  output  DROP_CNT_W  dropped-segment count, saturating

Behaviour:
- Clock and reset: single clock i_clk; i_rst is synchronous and active-high.
- Reset: state=IDLE. All outputs 0, except o_hdr_ready=1 (it is combinational from state IDLE).
- States: IDLE, CLASSIFY, REPORT.
- IDLE:
  - o_hdr_ready=1.
  - On i_hdr_valid in cycle T, latch all header inputs and go to CLASSIFY.
- CLASSIFY: one cycle, o_hdr_ready=0. Classification uses the latched flags, first match wins:
  - RST set -> RST. Accepted regardless of seq.
  - SYN&ACK -> SYN_ACK. Always accepted; rcv_nxt<=seq+1.
  - SYN -> SYN. Always accepted; rcv_nxt<=seq+1.
  - FIN -> FIN. Accepted only if seq==rcv_nxt; rcv_nxt<=rcv_nxt+payload_len+1.
  - ACK -> ACK. Accepted only if seq==rcv_nxt; rcv_nxt<=rcv_nxt+payload_len.
  - No SYN/FIN/RST/ACK set -> dropped.
- On accept:
  - o_rx_ctrl<=code, o_rx_ctrl_valid<=1 at T+2, state goes to REPORT.
  - If ACK flag set: o_remote_ack<=ack_number.
  - o_remote_window<=window_size.
- On drop (sequence mismatch or no usable flags): o_drop_count increments, saturating at all-ones. State returns to IDLE; no event is issued; rcv_nxt is unchanged.
- Arithmetic: all sequence arithmetic is 32-bit modulo 2^32, so wrap-around is legal. payload_len is zero-extended to 32 bits.
- REPORT:
  - o_rx_ctrl and o_rx_ctrl_valid are held stable until i_rx_ctrl_ack is sampled high.
  - Next cycle: o_rx_ctrl_valid=0, o_rx_ctrl=0, state=IDLE.
  - i_rx_ctrl_ack outside REPORT is ignored.
- Throughput: at most one header per 3 cycles when ack is immediate. Upstream must hold the header until o_hdr_ready&&i_hdr_valid.
- i_conn_reset (priority below i_rst, above everything else):
  - Next cycle: rcv_nxt, remote_ack, remote_window, o_rx_ctrl and o_rx_ctrl_valid are cleared and state=IDLE.
  - Any in-flight header or unacknowledged event is discarded.
  - o_drop_count is not cleared.
- i_rst mid-operation: state returns to IDLE with all outputs cleared in the following cycle.

Test Plan:
- Reset, then SYN+ACK (flags=0x12, seq=0x1000_0000, ack=0x0000_0101, win=0x4000) -> o_rx_ctrl=2, valid at T+2, o_rcv_nxt=0x1000_0001, o_remote_ack=0x101, o_remote_window=0x4000.
- After SYN_ACK, ACK with seq=0x1000_0001, len=100 -> code 3, o_rcv_nxt=0x1000_0065. Repeat with seq=0x1000_0000 -> no event, o_drop_count=1, o_rcv_nxt unchanged.
- SYN seq=0xFFFF_FFFE, then ACK seq=0xFFFF_FFFF len=3 -> o_rcv_nxt=0x0000_0002 (wrap).
- FIN flags=0x11, in-sequence, len=0 -> code 4 (FIN beats ACK), rcv_nxt+1. Hold i_rx_ctrl_ack low 5 cycles -> valid and code stable, o_hdr_ready=0 throughout.
- RST with mismatched seq -> code 5 accepted. Flags=0x08 (PSH only) -> dropped, counter+1.
- Event pending in REPORT, assert i_conn_reset -> next cycle valid=0, o_rcv_nxt=0, o_hdr_ready=1, drop count retained. Force counter to 0xFFFF and drop -> stays 0xFFFF.
